// File: rtl/led_pattern_sequencer_pkg.sv
// Shared encodings for the LED pattern sequencer: modes, FSM states, breathe direction.
// The mode encoding matches the AXI register map's cfg_mode field.
package led_pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } seq_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  // Clock cycles per base tick, never less than one.
  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
    if (tick_hz == 0 || clk_hz / tick_hz == 0) return 1;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_prescaler.sv
// Base tick generator: counts 0..TICK_DIV-1 while run is high, tick at the terminal count.
module led_tick_prescaler
  import led_pattern_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: shadows cfg_* on cfg_load and steps STATIC/BLINK/CHASE/BREATHE
// patterns into led_control/pwm_duty for led_driver.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned PWM_RESOLUTION = 8,
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned STEP_W         = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cfg_enable,
  input  logic [1:0]                cfg_mode,
  input  logic [NUM_LEDS-1:0]       cfg_pattern,
  input  logic [STEP_W-1:0]         cfg_step_ticks,
  input  logic [PWM_RESOLUTION-1:0] cfg_duty_max,
  input  logic                      cfg_load,
  output logic [NUM_LEDS-1:0]       led_control,
  output logic [PWM_RESOLUTION-1:0] pwm_duty,
  output logic                      step_pulse,
  output logic                      active
);

  seq_state_e                state_q, state_d;
  seq_mode_e                 mode_q;
  logic [NUM_LEDS-1:0]       pattern_q;
  logic [STEP_W-1:0]         step_q;
  logic [PWM_RESOLUTION-1:0] duty_max_q;

  logic [STEP_W-1:0]         step_cnt_q, step_cnt_d;
  logic [NUM_LEDS-1:0]       led_q, led_d;
  logic [PWM_RESOLUTION-1:0] duty_q, duty_d;
  breathe_dir_e              dir_q, dir_d;

  logic              tick;
  logic              step_evt;
  logic [STEP_W-1:0] step_last;

  led_tick_prescaler #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q != ST_RUN),
    .run    (state_q == ST_RUN),
    .tick   (tick)
  );

  // A step count of zero behaves as one tick per step.
  assign step_last = (step_q == '0) ? '0 : step_q - STEP_W'(1);
  assign step_evt  = (state_q == ST_RUN) && tick && (step_cnt_q == step_last);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q     <= MODE_STATIC;
      pattern_q  <= '0;
      step_q     <= STEP_W'(1);
      duty_max_q <= '0;
    end else if (cfg_load) begin
      mode_q     <= seq_mode_e'(cfg_mode);
      pattern_q  <= cfg_pattern;
      step_q     <= cfg_step_ticks;
      duty_max_q <= cfg_duty_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      led_q      <= '0;
      duty_q     <= '0;
      dir_q      <= DIR_UP;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    led_d      = led_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        led_d      = '0;
        duty_d     = '0;
        step_cnt_d = '0;
        if (cfg_enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        step_cnt_d = '0;
        dir_d      = DIR_UP;
        led_d      = pattern_q;
        duty_d     = (mode_q == MODE_BREATHE) ? '0 : duty_max_q;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (!cfg_enable) begin
          state_d = ST_IDLE;
          led_d   = '0;
          duty_d  = '0;
        end else if (cfg_load) begin
          state_d = ST_LOAD;
        end else begin
          if (tick) step_cnt_d = step_evt ? '0 : step_cnt_q + STEP_W'(1);
          if (step_evt) begin
            unique case (mode_q)
              MODE_STATIC: ;
              MODE_BLINK:  led_d = (led_q != '0) ? '0 : pattern_q;
              MODE_CHASE:  led_d = (led_q << 1) | (led_q >> (NUM_LEDS - 1));
              MODE_BREATHE: begin
                // Guarded compares keep the sweep inside 0..duty_max without wrap.
                if (dir_q == DIR_UP) begin
                  if (duty_q >= duty_max_q) begin
                    if (duty_max_q != '0) begin
                      dir_d  = DIR_DOWN;
                      duty_d = duty_max_q - PWM_RESOLUTION'(1);
                    end else begin
                      duty_d = '0;
                    end
                  end else begin
                    duty_d = duty_q + PWM_RESOLUTION'(1);
                  end
                end else begin
                  if (duty_q == '0) begin
                    if (duty_max_q != '0) begin
                      dir_d  = DIR_UP;
                      duty_d = PWM_RESOLUTION'(1);
                    end
                  end else begin
                    duty_d = duty_q - PWM_RESOLUTION'(1);
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign led_control = led_q;
  assign pwm_duty    = duty_q;
  assign step_pulse  = step_evt;
  assign active      = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer at CLK_FREQ_HZ=1000, TICK_HZ=100 (10 clk per tick).
module tb_led_pattern_sequencer;

  localparam int SEL_LED   = 0;
  localparam int SEL_DUTY  = 1;
  localparam int SEL_PULSE = 2;
  localparam int SEL_ACT   = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_pattern;
  logic [15:0] cfg_step_ticks;
  logic [7:0]  cfg_duty_max;
  logic        cfg_load;
  logic [7:0]  led_control;
  logic [7:0]  pwm_duty;
  logic        step_pulse;
  logic        active;

  led_pattern_sequencer #(
    .NUM_LEDS       (8),
    .PWM_RESOLUTION (8),
    .CLK_FREQ_HZ    (1000),
    .TICK_HZ        (100),
    .STEP_W         (16)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cfg_enable     (cfg_enable),
    .cfg_mode       (cfg_mode),
    .cfg_pattern    (cfg_pattern),
    .cfg_step_ticks (cfg_step_ticks),
    .cfg_duty_max   (cfg_duty_max),
    .cfg_load       (cfg_load),
    .led_control    (led_control),
    .pwm_duty       (pwm_duty),
    .step_pulse     (step_pulse),
    .active         (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_LED:   return 32'(led_control);
      SEL_DUTY:  return 32'(pwm_duty);
      SEL_PULSE: return 32'(step_pulse);
      default:   return 32'(active);
    endcase
  endfunction

  task automatic expect_at(input int unsigned c, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  // Cycle index = number of rising edges seen; outputs sampled 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_val(sb[i].tag, observe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check_val({sb[i].tag, "_stale"}, 32'(sb[i].cyc), 32'(cyc));
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int unsigned target);
    int unsigned budget = 5000;
    while (cyc < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
  endtask

  task automatic drain();
    int unsigned budget = 5000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Called at a negedge; base is the first cycle the LOAD init values are visible.
  task automatic apply(input logic en, input logic ld, input logic [1:0] md, input logic [7:0] pat,
                       input logic [15:0] st, input logic [7:0] dm, output int unsigned base);
    cfg_enable = en; cfg_load = ld; cfg_mode = md;
    cfg_pattern = pat; cfg_step_ticks = st; cfg_duty_max = dm;
    base = cyc + 2;
  endtask

  task automatic end_load();
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  logic [7:0] chase_a[4]   = '{8'h81, 8'h03, 8'h06, 8'h0C};
  logic [7:0] chase_b[3]   = '{8'h80, 8'h01, 8'h02};
  logic [7:0] breathe_a[8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};

  initial begin
    int unsigned b, b1, c;
    resetn = 1'b0; cfg_enable = 1'b0; cfg_load = 1'b0; cfg_mode = 2'd0;
    cfg_pattern = 8'h00; cfg_step_ticks = 16'd1; cfg_duty_max = 8'h00;

    for (int unsigned k = 1; k <= 3; k++) begin
      expect_at(k, SEL_LED, 0, "rst_led");
      expect_at(k, SEL_DUTY, 0, "rst_duty");
      expect_at(k, SEL_PULSE, 0, "rst_pulse");
      expect_at(k, SEL_ACT, 0, "rst_active");
    end
    wait_cyc(3);
    resetn = 1'b1;
    drain();

    // STATIC: held for 1000 cycles, step pulse every 10 clk
    apply(1, 1, 2'd0, 8'hA5, 16'd1, 8'h80, b);
    expect_at(b - 1, SEL_ACT, 1, "static_load_active");
    expect_at(b - 1, SEL_LED, 0, "static_load_led");
    expect_at(b, SEL_LED, 8'hA5, "static_init_led");
    expect_at(b, SEL_DUTY, 8'h80, "static_init_duty");
    for (int unsigned k = 0; k < 100; k++) begin
      expect_at(b + 10*k + 5, SEL_LED, 8'hA5, "static_led");
      expect_at(b + 10*k + 5, SEL_DUTY, 8'h80, "static_duty");
      expect_at(b + 10*k + 4, SEL_PULSE, 0, "static_nopulse");
      expect_at(b + 10*k + 9, SEL_PULSE, 1, "static_pulse");
    end
    end_load();
    drain();

    // BLINK, step_ticks=2: 20-clk toggle period
    apply(1, 1, 2'd1, 8'hA5, 16'd2, 8'h80, b);
    expect_at(b, SEL_DUTY, 8'h80, "blink_duty");
    for (int unsigned k = 0; k < 4; k++) begin
      expect_at(b + 20*k, SEL_LED, (k % 2 == 1) ? 8'h00 : 8'hA5, "blink_led");
      expect_at(b + 20*k + 18, SEL_LED, (k % 2 == 1) ? 8'h00 : 8'hA5, "blink_led_hold");
      if (k >= 1) begin
        expect_at(b + 20*k - 1, SEL_PULSE, 1, "blink_pulse");
        expect_at(b + 20*k - 11, SEL_PULSE, 0, "blink_midtick_nopulse");
      end
    end
    end_load();
    drain();

    // CHASE: rotate left, MSB wraps; step_ticks=0 acts as 1
    apply(1, 1, 2'd2, 8'h81, 16'd1, 8'h80, b);
    for (int unsigned k = 0; k < 4; k++) begin
      expect_at(b + 10*k, SEL_LED, 32'(chase_a[k]), "chase_led");
      if (k >= 1) expect_at(b + 10*k - 1, SEL_PULSE, 1, "chase_pulse");
    end
    end_load();
    drain();
    apply(1, 1, 2'd2, 8'h80, 16'd0, 8'h80, b);
    for (int unsigned k = 0; k < 3; k++) begin
      expect_at(b + 10*k, SEL_LED, 32'(chase_b[k]), "chase_wrap_led");
      if (k >= 1) expect_at(b + 10*k - 1, SEL_PULSE, 1, "chase_step0_pulse");
    end
    end_load();
    drain();

    // BREATHE: triangle 0..3..0, then duty_max=0 holds at 0
    apply(1, 1, 2'd3, 8'h5A, 16'd1, 8'd3, b);
    for (int unsigned k = 0; k < 8; k++) begin
      expect_at(b + 10*k, SEL_DUTY, 32'(breathe_a[k]), "breathe_duty");
      expect_at(b + 10*k, SEL_LED, 8'h5A, "breathe_led");
    end
    end_load();
    drain();
    apply(1, 1, 2'd3, 8'h5A, 16'd1, 8'd0, b);
    for (int unsigned k = 0; k < 4; k++) begin
      expect_at(b + 10*k, SEL_DUTY, 0, "breathe_zero_duty");
      expect_at(b + 10*k, SEL_LED, 8'h5A, "breathe_zero_led");
    end
    end_load();
    drain();

    // Restart into CHASE mid-BLINK: init pattern, prescaler and step counter cleared
    apply(1, 1, 2'd1, 8'h3C, 16'd1, 8'h10, b);
    expect_at(b, SEL_LED, 8'h3C, "ctl_blink_led0");
    expect_at(b + 10, SEL_LED, 8'h00, "ctl_blink_led1");
    end_load();
    wait_cyc(b + 14);
    apply(1, 1, 2'd2, 8'h3C, 16'd1, 8'h10, b1);
    expect_at(b1, SEL_LED, 8'h3C, "ctl_restart_led");
    expect_at(b1 + 3, SEL_PULSE, 0, "ctl_restart_nopulse");
    expect_at(b1 + 8, SEL_PULSE, 0, "ctl_restart_nopulse");
    expect_at(b1 + 9, SEL_PULSE, 1, "ctl_restart_pulse");
    expect_at(b1 + 10, SEL_LED, 8'h78, "ctl_restart_chase");
    end_load();
    drain();

    // cfg_enable=0 in RUN: outputs zero after the next edge
    c = cyc;
    cfg_enable = 1'b0;
    expect_at(c + 1, SEL_LED, 0, "ctl_disable_led");
    expect_at(c + 1, SEL_DUTY, 0, "ctl_disable_duty");
    expect_at(c + 1, SEL_ACT, 0, "ctl_disable_active");
    expect_at(c + 15, SEL_LED, 0, "ctl_idle_led");
    drain();

    // cfg_load with enable=0: IDLE wins, shadow still captured
    apply(1, 1, 2'd0, 8'hFF, 16'd1, 8'h20, b);
    expect_at(b, SEL_LED, 8'hFF, "ctl_static_ff");
    end_load();
    drain();
    c = cyc;
    apply(0, 1, 2'd0, 8'h11, 16'd1, 8'h40, b);
    expect_at(c + 1, SEL_LED, 0, "ctl_loadoff_led");
    expect_at(c + 1, SEL_ACT, 0, "ctl_loadoff_active");
    expect_at(c + 5, SEL_ACT, 0, "ctl_loadoff_stays_idle");
    end_load();
    cfg_pattern = 8'h22;
    cfg_duty_max = 8'h55;
    drain();
    c = cyc;
    cfg_enable = 1'b1;
    expect_at(c + 2, SEL_LED, 8'h11, "ctl_shadow_led");
    expect_at(c + 2, SEL_DUTY, 8'h40, "ctl_shadow_duty");
    expect_at(c + 2, SEL_ACT, 1, "ctl_shadow_active");
    drain();

    // Reset mid-RUN: outputs clear after the next edge, shadow back to defaults
    c = cyc;
    resetn = 1'b0;
    expect_at(c + 1, SEL_LED, 0, "midrst_led");
    expect_at(c + 1, SEL_DUTY, 0, "midrst_duty");
    expect_at(c + 1, SEL_ACT, 0, "midrst_active");
    @(negedge clk);
    resetn = 1'b1;
    expect_at(c + 2, SEL_ACT, 1, "midrst_reload_active");
    expect_at(c + 3, SEL_LED, 0, "midrst_shadow_led");
    expect_at(c + 3, SEL_DUTY, 0, "midrst_shadow_duty");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
